// File: rtl/fraise_pkg.sv
// Shared register map, bit positions and sequencer states for the fraise
// likelihood accumulator.
package fraise_pkg;

  localparam logic [11:0] OFF_CTRL   = 12'h800;
  localparam logic [11:0] OFF_STATUS = 12'h804;
  localparam logic [11:0] OFF_OBS    = 12'h808;
  localparam logic [11:0] OFF_RESULT = 12'h810;
  localparam logic [11:0] OFF_ARGMAX = 12'h820;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQEN_BIT  = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/fraise_array.sv
// Single-port likelihood array: synchronous read, per-byte write enables.
// Read data holds its value until the next read.
module fraise_array
  import fraise_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int ArraySize = 64
) (
  input  logic                         clk_i,
  input  logic                         en,
  input  logic                         we,
  input  logic [DataWidth/8-1:0]       ben,
  input  logic [$clog2(ArraySize)-1:0] addr,
  input  logic [DataWidth-1:0]         wdata,
  output logic [DataWidth-1:0]         rdata
);

  logic [DataWidth-1:0] mem [ArraySize];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DataWidth/8; b++) begin
          if (ben[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/fraise_top.sv
// Bus-mapped likelihood accumulator: sums one array word per feature for each
// class, then reports the per-class totals and the winning class.
module fraise_top
  import fraise_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 32,
  parameter int MatrixSize   = 4,
  parameter int ArraySize    = 64,
  parameter int Nword_used   = 3,
  parameter int NbrHostsLog2 = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n,
  input  logic                    req_valid_i,
  output logic                    ready_o,
  input  logic [NbrHostsLog2-1:0] req_host_addr_i,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic                    req_wen_i,
  input  logic [DataWidth-1:0]    req_wdata_i,
  input  logic [DataWidth/8-1:0]  req_ben_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DataWidth-1:0]    resp_data_o,
  output logic [NbrHostsLog2-1:0] resp_ini_addr_o,
  output logic                    irq_o
);

  localparam int ArrBits   = $clog2(ArraySize);
  localparam int FeatBits  = $clog2(MatrixSize);
  localparam int KBits     = (FeatBits > 0) ? FeatBits : 1;
  localparam int JBits     = (Nword_used > 1) ? $clog2(Nword_used) : 1;
  localparam int RowStride = ArraySize / MatrixSize;

  function automatic logic [DataWidth-1:0] merge_bytes(input logic [DataWidth-1:0]   old,
                                                       input logic [DataWidth-1:0]   wdata,
                                                       input logic [DataWidth/8-1:0] ben);
    merge_bytes = old;
    for (int b = 0; b < DataWidth/8; b++) begin
      if (ben[b]) merge_bytes[b*8 +: 8] = wdata[b*8 +: 8];
    end
  endfunction

  seq_state_e           state, state_next;
  logic [DataWidth-1:0] result      [MatrixSize];
  logic [DataWidth-1:0] result_next [MatrixSize];
  logic [DataWidth-1:0] obs, rdata_reg, arr_rdata, resp_data_q;
  logic [KBits-1:0]     argmax, argmax_next, res_idx, k_p0, k_p1;
  logic [JBits-1:0]     j_p0, j_p1;
  logic [FeatBits-1:0]  feat_p0;
  logic [ArrBits-1:0]   seq_addr, arr_addr;
  logic [11:0]          off;
  logic busy, last, in_array, in_result, accept, wr, rd, start_fire, seq_re;
  logic bus_arr, arr_en, arr_we, irq_en, done, resp_arr;
  logic unused_addr;

  assign off         = req_addr_i[11:0];
  assign unused_addr = ^req_addr_i[AddrWidth-1:12];
  assign busy        = (state == RUN);
  assign in_array    = int'(off) < 4 * ArraySize;
  assign in_result   = (int'(off) >= int'(OFF_RESULT)) &&
                       (int'(off) < int'(OFF_RESULT) + 4 * MatrixSize) && (off[1:0] == 2'b00);
  assign res_idx     = KBits'((off - OFF_RESULT) >> 2);

  assign ready_o    = (!resp_valid_o || resp_ready_i) && !(busy && in_array);
  assign accept     = req_valid_i && ready_o;
  assign wr         = accept && req_wen_i;
  assign rd         = accept && !req_wen_i;
  assign start_fire = wr && (off == OFF_CTRL) && req_ben_i[0] &&
                      req_wdata_i[CTRL_START_BIT] && !busy;
  assign last       = busy && (k_p1 == KBits'(MatrixSize - 1)) && (j_p1 == JBits'(Nword_used - 1));
  assign irq_o      = done && irq_en;

  // p0: choose the (class, feature) word to read; START issues step 0 directly
  always_comb begin
    k_p0 = '0;
    j_p0 = '0;
    if (busy) begin
      if (j_p1 == JBits'(Nword_used - 1)) begin
        k_p0 = k_p1 + 1'b1;
      end else begin
        k_p0 = k_p1;
        j_p0 = j_p1 + 1'b1;
      end
    end
    feat_p0  = obs[int'(j_p0) * FeatBits +: FeatBits];
    seq_addr = ArrBits'(int'(k_p0) * RowStride + int'(j_p0) * MatrixSize + int'(feat_p0));
  end

  assign seq_re   = start_fire || (busy && !last);
  assign bus_arr  = accept && in_array;
  assign arr_en   = seq_re || bus_arr;
  assign arr_we   = bus_arr && req_wen_i;
  assign arr_addr = seq_re ? seq_addr : off[ArrBits+1:2];

  fraise_array #(
    .DataWidth (DataWidth),
    .ArraySize (ArraySize)
  ) u_array (
    .clk_i (clk_i),
    .en    (arr_en),
    .we    (arr_we),
    .ben   (req_ben_i),
    .addr  (arr_addr),
    .wdata (req_wdata_i),
    .rdata (arr_rdata)
  );

  // p1: accumulate the word read last cycle and rank the updated totals
  always_comb begin
    argmax_next = '0;
    for (int k = 0; k < MatrixSize; k++) result_next[k] = result[k];
    if (busy) result_next[k_p1] = result[k_p1] + arr_rdata;
    for (int k = 1; k < MatrixSize; k++) begin
      if (result_next[k] > result_next[argmax_next]) argmax_next = KBits'(k);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_fire) state_next = RUN;
      RUN:     if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata_reg = '0;
    if (in_result) begin
      rdata_reg = result[res_idx];
    end else begin
      case (off)
        OFF_CTRL:   rdata_reg[CTRL_IRQEN_BIT] = irq_en;
        OFF_STATUS: begin
          rdata_reg[STATUS_BUSY_BIT] = busy;
          rdata_reg[STATUS_DONE_BIT] = done;
        end
        OFF_OBS:    rdata_reg = obs;
        OFF_ARGMAX: rdata_reg = DataWidth'(argmax);
        default:    rdata_reg = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      irq_en <= 1'b0;
      obs    <= '0;
      argmax <= '0;
      k_p1   <= '0;
      j_p1   <= '0;
      for (int k = 0; k < MatrixSize; k++) result[k] <= '0;
    end else begin
      state <= state_next;
      if (wr && (off == OFF_CTRL) && req_ben_i[0]) irq_en <= req_wdata_i[CTRL_IRQEN_BIT];
      if (wr && (off == OFF_OBS) && !busy) obs <= merge_bytes(obs, req_wdata_i, req_ben_i);
      if (start_fire) begin
        for (int k = 0; k < MatrixSize; k++) result[k] <= '0;
        k_p1 <= '0;
        j_p1 <= '0;
      end else if (busy) begin
        for (int k = 0; k < MatrixSize; k++) result[k] <= result_next[k];
        k_p1 <= k_p0;
        j_p1 <= j_p0;
      end
      if (last) argmax <= argmax_next;
      if (last) begin
        done <= 1'b1;
      end else if (start_fire) begin
        done <= 1'b0;
      end else if (wr && (off == OFF_STATUS) && req_wdata_i[STATUS_DONE_BIT]) begin
        done <= 1'b0;
      end
    end
  end

  // Array reads complete a cycle late, so their response data comes straight
  // from the array's read register, which stays put until the next read.
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      resp_valid_o    <= 1'b0;
      resp_data_q     <= '0;
      resp_ini_addr_o <= '0;
      resp_arr        <= 1'b0;
    end else if (accept) begin
      resp_valid_o    <= 1'b1;
      resp_data_q     <= rd ? rdata_reg : '0;
      resp_ini_addr_o <= req_host_addr_i;
      resp_arr        <= rd && in_array;
    end else if (resp_ready_i) begin
      resp_valid_o <= 1'b0;
      resp_arr     <= 1'b0;
    end
  end

  assign resp_data_o = resp_arr ? arr_rdata : resp_data_q;

endmodule

// File: tb/tb_fraise_top.sv
// Directed bench for fraise_top: bus transfers checked through a response
// scoreboard, plus sequencer timing, result, argmax and reset checks.
module tb_fraise_top;
  import fraise_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, req_valid, ready, req_wen, resp_valid, resp_ready, irq;
  logic [0:0]  req_host, resp_ini;
  logic [31:0] req_addr, req_wdata, resp_data;
  logic [3:0]  req_ben;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [0:0]  host;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] mdl [64];

  always #5 clk = ~clk;

  fraise_top dut (
    .clk_i           (clk),
    .reset_n         (reset_n),
    .req_valid_i     (req_valid),
    .ready_o         (ready),
    .req_host_addr_i (req_host),
    .req_addr_i      (req_addr),
    .req_wen_i       (req_wen),
    .req_wdata_i     (req_wdata),
    .req_ben_i       (req_ben),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_data_o     (resp_data),
    .resp_ini_addr_o (resp_ini),
    .irq_o           (irq)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model_res(input int k, input logic [31:0] obsv);
    logic [31:0] s = '0;
    for (int j = 0; j < 3; j++) s += mdl[k*16 + j*4 + int'(obsv[j*2 +: 2])];
    return s;
  endfunction

  function automatic logic [31:0] model_argmax(input logic [31:0] obsv);
    int best = 0;
    for (int k = 1; k < 4; k++) if (model_res(k, obsv) > model_res(best, obsv)) best = k;
    return 32'(best);
  endfunction

  // One bus transfer; hold>0 keeps resp_ready low for that many extra cycles.
  task automatic xfer(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                      input logic [3:0] ben, input logic host, input logic [31:0] expd,
                      input int hold, output int waited);
    exp_t e, got;
    logic [31:0] first;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_wen = wen; req_wdata = wdata;
    req_ben = ben; req_host = host; resp_ready = (hold == 0);
    #1;
    waited = 0;
    while (!ready && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    if (waited >= 100) check("accept_timeout", 32'(waited), 32'd0);
    e.data = wen ? 32'd0 : expd;
    e.host = host;
    sb.push_back(e);
    if (wen && addr < 32'd256) begin
      for (int b = 0; b < 4; b++) if (ben[b]) mdl[addr[7:2]][b*8 +: 8] = wdata[b*8 +: 8];
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("resp_valid_next_cycle", 32'(resp_valid), 32'd1);
    got = sb.pop_front();
    check("resp_data", resp_data, got.data);
    check("resp_host", 32'(resp_ini), 32'(got.host));
    first = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_data", resp_data, first);
      check("hold_ready_low", 32'(ready), 32'd0);
    end
    resp_ready = 1'b1;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] d);
    int w;
    xfer(addr, 1'b1, d, 4'hF, 1'b0, 32'd0, 0, w);
  endtask

  task automatic rd32(input string tag, input logic [31:0] addr, input logic [31:0] expd);
    int w;
    xfer(addr, 1'b0, 32'd0, 4'h0, 1'b1, expd, 0, w);
    check(tag, resp_data, expd);
  endtask

  // Called at a negedge; counts cycles with an array access blocked by BUSY.
  task automatic count_busy(output int n);
    req_addr = 32'd0;
    req_valid = 1'b0;
    #1;
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_ini", 32'(resp_ini), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    sb.delete();
    #1;
    check("rst_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    int n, w;
    logic [31:0] exp_res [4];
    logic [31:0] obsv;
    exp_res = '{32'd15, 32'd63, 32'd111, 32'd159};
    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1; req_addr = '0;
    req_wen = 1'b0; req_wdata = '0; req_ben = '0; req_host = '0;
    do_reset();
    rd32("rst_ctrl", 32'h800, 32'd0);
    rd32("rst_status", 32'h804, 32'd0);
    rd32("rst_obs", 32'h808, 32'd0);
    rd32("rst_argmax", 32'h820, 32'd0);
    rd32("rst_result0", 32'h810, 32'd0);

    // Byte-enable write and read-back with host ID echo
    wr32(32'd20, 32'd0);
    xfer(32'd20, 1'b1, 32'h11223344, 4'b0101, 1'b1, 32'd0, 0, w);
    xfer(32'd20, 1'b0, 32'd0, 4'h0, 1'b1, 32'h00220044, 0, w);
    check("ben_readback", resp_data, 32'h00220044);
    check("ben_host_echo", 32'(resp_ini), 32'd1);

    for (int i = 0; i < 64; i++) xfer(32'(i*4), 1'b1, 32'(i), 4'hF, 1'(i), 32'd0, 0, w);

    // Main computation
    obsv = 32'h24;
    wr32(32'h808, obsv);
    rd32("obs_readback", 32'h808, obsv);
    wr32(32'h800, 32'h3);
    count_busy(n);
    check("busy_cycles", 32'(n), 32'd12);
    check("irq_after_done", 32'(irq), 32'd1);
    rd32("status_done", 32'h804, 32'h2);
    for (int k = 0; k < 4; k++) rd32($sformatf("result%0d", k), 32'h810 + 32'(4*k), exp_res[k]);
    rd32("argmax", 32'h820, 32'd3);
    rd32("ctrl_start_reads0", 32'h800, 32'h2);

    // DONE write-1-clear drops the interrupt
    wr32(32'h804, 32'h2);
    check("irq_cleared", 32'(irq), 32'd0);
    rd32("status_cleared", 32'h804, 32'd0);

    // START and OBS write while busy are both ignored
    wr32(32'h800, 32'h3);
    wr32(32'h800, 32'h3);
    wr32(32'h808, 32'h3F);
    count_busy(n);
    check("busy_no_restart", 32'(n), 32'd8);
    rd32("obs_frozen", 32'h808, obsv);
    rd32("result3_rerun", 32'h81C, 32'd159);

    // Array read during BUSY stalls until the run ends
    wr32(32'h800, 32'h1);
    xfer(32'd28, 1'b0, 32'd0, 4'h0, 1'b1, 32'd7, 0, w);
    check("array_rd_stall", 32'(w), 32'd11);
    check("array_rd_busy_data", resp_data, 32'd7);

    // Wrapping sum and all-equal totals
    obsv = 32'd0;
    wr32(32'h808, obsv);
    wr32(32'd0, 32'hFFFF_FFFF);
    wr32(32'd16, 32'h16);
    wr32(32'd32, 32'd0);
    for (int k = 1; k < 4; k++) for (int j = 0; j < 3; j++) wr32(32'(4*(k*16 + j*4)), 32'd7);
    wr32(32'h800, 32'h1);
    count_busy(n);
    check("busy_cycles_tie", 32'(n), 32'd12);
    rd32("result0_wrap", 32'h810, 32'd21);
    rd32("result0_model", 32'h810, model_res(0, obsv));
    rd32("result2_model", 32'h818, model_res(2, obsv));
    rd32("argmax_all_equal", 32'h820, 32'd0);

    // Tie between classes 1 and 2 resolves to the lower index
    wr32(32'd64, 32'd107);
    wr32(32'd128, 32'd107);
    wr32(32'h800, 32'h1);
    count_busy(n);
    rd32("result1_tie", 32'h814, model_res(1, obsv));
    rd32("argmax_tie", 32'h820, model_argmax(obsv));
    check("argmax_tie_value", model_argmax(obsv), 32'd1);

    // Response back-pressure
    xfer(32'd20, 1'b0, 32'd0, 4'h0, 1'b1, mdl[5], 3, w);
    xfer(32'd24, 1'b0, 32'd0, 4'h0, 1'b0, mdl[6], 0, w);
    check("accept_after_release", 32'(w), 32'd0);

    // Unmapped space
    rd32("unmapped_rd", 32'h900, 32'd0);
    wr32(32'h900, 32'hDEAD_BEEF);
    rd32("unmapped_wr_ignored", 32'h900, 32'd0);
    rd32("reserved_80c", 32'h80C, 32'd0);

    // Reset in the middle of a run
    wr32(32'h808, 32'h24);
    wr32(32'h800, 32'h3);
    repeat (4) @(negedge clk);
    do_reset();
    rd32("midrst_status", 32'h804, 32'd0);
    for (int k = 0; k < 4; k++) rd32($sformatf("midrst_result%0d", k), 32'h810 + 32'(4*k), 32'd0);
    rd32("midrst_argmax", 32'h820, 32'd0);
    rd32("midrst_obs", 32'h808, 32'd0);
    rd32("midrst_ctrl", 32'h800, 32'd0);
    rd32("array_survives_reset", 32'd24, mdl[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
